// File: rtl/add4_rr_sched.sv
// add4_rr_sched: shares one external 2-stage pipelined 4-operand adder among
// N requesters. The requester is picked round-robin. A valid/ID shadow pipeline
// follows the adder stages, so each sum leaves with the ID of its requester.
// Backpressure on the response port freezes the adder and the shadow pipeline.
module add4_rr_sched #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req_valid,
  input  logic [N*32-1:0] i_req_ops,
  output logic [N-1:0]    o_req_ready,
  output logic            o_add_enable,
  output logic [7:0]      o_add_a,
  output logic [7:0]      o_add_b,
  output logic [7:0]      o_add_c,
  output logic [7:0]      o_add_d,
  input  logic [9:0]      i_add_sum,
  output logic            o_rsp_valid,
  output logic [ID_W-1:0] o_rsp_id,
  output logic [9:0]      o_rsp_sum,
  input  logic            i_rsp_ready,
  output logic            o_busy
);

  logic            r_v1;
  logic            r_v2;
  logic [ID_W-1:0] r_id1;
  logic [ID_W-1:0] r_id2;
  logic [ID_W-1:0] r_ptr;

  logic            w_adv;
  logic            w_anyGrant;
  logic [ID_W-1:0] w_grantIdx;
  logic [ID_W-1:0] w_ptrNext;
  logic [N-1:0]    w_grant;
  logic [31:0]     w_ops;

  // Index that lies off positions after base, wrapped modulo N.
  function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[ID_W-1:0];
  endfunction

  // The pipeline may advance when stage 2 is empty or its result is leaving now.
  assign w_adv        = ~r_v2 | i_rsp_ready;
  assign o_add_enable = w_adv;

  // Find the first valid requester at or after the pointer.
  // No grant is given while the pipeline is stalled or in reset.
  always_comb begin
    w_anyGrant = 1'b0;
    w_grantIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_anyGrant && i_req_valid[wrapIdx(r_ptr, i)]) begin
        w_anyGrant = 1'b1;
        w_grantIdx = wrapIdx(r_ptr, i);
      end
    end
    if (!i_rst_n || !w_adv) begin
      w_anyGrant = 1'b0;
      w_grantIdx = '0;
    end
  end

  assign w_grant     = w_anyGrant ? (N'(1) << w_grantIdx) : '0;
  assign o_req_ready = w_grant;
  assign w_ptrNext   = (w_grantIdx == ID_W'(N - 1)) ? '0 : w_grantIdx + ID_W'(1);

  // Route the granted requester's operand slice to the adder. A bubble drives zeros.
  always_comb begin
    w_ops = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) w_ops = i_req_ops[32*k +: 32];
    end
  end

  assign o_add_a = w_ops[7:0];
  assign o_add_b = w_ops[15:8];
  assign o_add_c = w_ops[23:16];
  assign o_add_d = w_ops[31:24];

  // Shadow pipeline and round-robin pointer.
  // Both are frozen together with the adder while the response is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
      r_ptr <= '0;
    end else begin
      if (w_adv) begin
        r_v1  <= w_anyGrant;
        r_id1 <= w_grantIdx;
        r_v2  <= r_v1;
        r_id2 <= r_id1;
      end
      if (w_anyGrant) r_ptr <= w_ptrNext;
    end
  end

  assign o_rsp_valid = r_v2;
  assign o_rsp_id    = r_id2;
  assign o_rsp_sum   = i_add_sum;
  assign o_busy      = r_v1 | r_v2;

endmodule

// File: tb/tb_add4_rr_sched.sv
// tb_add4_rr_sched: drives add4_rr_sched with directed and random requests.
// It models the shared 2-stage adder. A scoreboard monitor holds the transfers
// in flight and predicts grants, responses, enable and busy every cycle.
module tb_add4_rr_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [127:0] req_ops = '0;
  logic [N-1:0] req_ready;
  logic         add_enable;
  logic [7:0]   add_a, add_b, add_c, add_d;
  logic [9:0]   add_sum;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [9:0]   rsp_sum;
  logic         rsp_ready = 1'b1;
  logic         busy;

  int checks = 0;
  int failures = 0;

  add4_rr_sched #(.N(N), .ID_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_ops(req_ops),
    .o_req_ready(req_ready), .o_add_enable(add_enable),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_c(add_c), .o_add_d(add_d),
    .i_add_sum(add_sum), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_sum(rsp_sum), .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // External 2-stage adder: stage 1 forms the sum and stage 2 registers it. It shares the enable and the reset.
  logic [9:0] addS1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addS1   <= '0;
      add_sum <= '0;
    end else if (add_enable) begin
      addS1   <= {2'b0, add_a} + {2'b0, add_b} + {2'b0, add_c} + {2'b0, add_d};
      add_sum <= addS1;
    end
  end

  // Scoreboard: each accepted operand set waits here until its response is consumed.
  // age counts how many pipeline advances the set has seen. It is at the output once age >= 2.
  typedef struct {int id; int sum; int age;} entry_t;
  entry_t q[$];
  int     mPtr = 0;
  bit     mExpValid, mExpAdv;
  int     mGIdx;
  logic [N-1:0] mExpReady;
  logic [31:0]  mExpOps, mSlice;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mPtr = 0;
    end else begin
      mExpValid = (q.size() > 0) && (q[0].age >= 2);
      mExpAdv   = !mExpValid || rsp_ready;
      mGIdx = -1;
      for (int i = 0; i < N; i++) begin
        if (mGIdx < 0 && req_valid[(mPtr + i) % N]) mGIdx = (mPtr + i) % N;
      end
      mExpReady = (mExpAdv && mGIdx >= 0) ? N'(1 << mGIdx) : '0;
      mExpOps   = '0;
      if (mExpReady != 0) mExpOps = req_ops[32*mGIdx +: 32];

      checks++;
      if (rsp_valid !== mExpValid) begin
        failures++;
        $display("FAIL mon_rsp_valid t=%0t: got %0b expected %0b", $time, rsp_valid, mExpValid);
      end
      if (mExpValid) begin
        checks++;
        if (rsp_id !== 2'(q[0].id) || rsp_sum !== 10'(q[0].sum)) begin
          failures++;
          $display("FAIL mon_rsp_data t=%0t: got id=%0d sum=%0d expected id=%0d sum=%0d",
                   $time, rsp_id, rsp_sum, q[0].id, q[0].sum);
        end
      end
      checks++;
      if (add_enable !== mExpAdv) begin
        failures++;
        $display("FAIL mon_enable t=%0t: got %0b expected %0b", $time, add_enable, mExpAdv);
      end
      checks++;
      if (req_ready !== mExpReady) begin
        failures++;
        $display("FAIL mon_req_ready t=%0t: got %b expected %b", $time, req_ready, mExpReady);
      end
      checks++;
      if ({add_d, add_c, add_b, add_a} !== mExpOps) begin
        failures++;
        $display("FAIL mon_operands t=%0t: got %h expected %h", $time, {add_d, add_c, add_b, add_a}, mExpOps);
      end
      checks++;
      if (busy !== (q.size() > 0)) begin
        failures++;
        $display("FAIL mon_busy t=%0t: got %0b expected %0b", $time, busy, q.size() > 0);
      end

      if (mExpValid && rsp_ready) void'(q.pop_front());
      if (mExpAdv) foreach (q[i]) q[i].age++;
      if (mExpReady != 0) begin
        mSlice = req_ops[32*mGIdx +: 32];
        q.push_back('{id: mGIdx,
                      sum: int'(mSlice[7:0]) + int'(mSlice[15:8]) + int'(mSlice[23:16]) + int'(mSlice[31:24]),
                      age: 1});
        mPtr = (mGIdx + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_ops = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0 || add_enable !== 1'b1 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
        busy !== 1'b0 || {add_d, add_c, add_b, add_a} !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b en=%0b rv=%0b id=%0d busy=%0b ops=%h expected 0,1,0,0,0,0",
               req_ready, add_enable, rsp_valid, rsp_id, busy, {add_d, add_c, add_b, add_a});
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    idle(3);
    req_valid = 4'b0100;
    req_ops[95:64] = {8'd4, 8'd3, 8'd2, 8'd1};
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: got rsp_valid=%0b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 10'd10) begin
      failures++;
      $display("FAIL single_rsp: got v=%0b id=%0d sum=%0d expected v=1 id=2 sum=10", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after: got rsp_valid=%0b expected 0", rsp_valid);
    end
    idle(2);
  endtask

  // The pointer is 3 after test_single, so the grants rotate starting at requester 3.
  task automatic test_rotate();
    req_ops = {128{1'b1}};
    req_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << ((3 + i) % 4))) begin
        failures++;
        $display("FAIL rotate_grant[%0d]: got %b expected %b", i, req_ready, 4'(1 << ((3 + i) % 4)));
      end
      if (i >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((3 + i - 2) % 4) || rsp_sum !== 10'd1020) begin
          failures++;
          $display("FAIL rotate_rsp[%0d]: got v=%0b id=%0d sum=%0d expected v=1 id=%0d sum=1020",
                   i, rsp_valid, rsp_id, rsp_sum, (3 + i - 2) % 4);
        end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int stall = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      req_valid = '0;
      req_valid[0] = (sent < 3);
      req_ops[31:0] = {4{8'(sent + 1)}};
      if (rsp_valid && got == 0 && stall < 3) begin
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
      end else begin
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      if (!rsp_ready) begin
        checks++;
        if (add_enable !== 1'b0 || req_ready !== 4'b0 || rsp_valid !== 1'b1 ||
            rsp_id !== 2'd0 || rsp_sum !== 10'd4) begin
          failures++;
          $display("FAIL bp_hold[%0d]: got en=%0b ready=%b v=%0b id=%0d sum=%0d expected en=0 ready=0000 v=1 id=0 sum=4",
                   stall, add_enable, req_ready, rsp_valid, rsp_id, rsp_sum);
        end
        stall++;
      end
      if (req_ready[0]) sent++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 10'(4 * (got + 1))) begin
          failures++;
          $display("FAIL bp_order[%0d]: got id=%0d sum=%0d expected id=0 sum=%0d", got, rsp_id, rsp_sum, 4 * (got + 1));
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 3 || stall != 3) begin
      failures++;
      $display("FAIL bp_count: got responses=%0d stalls=%0d expected 3 and 3", got, stall);
    end
    idle(4);
  endtask

  // The pointer is 1 here. A grant to 2 moves it to 3, so 3 beats 1. Then 1 is served and the pointer lands on 2.
  task automatic test_pointer();
    req_valid = 4'b0100;
    req_ops = {$urandom, $urandom, $urandom, $urandom};
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL ptr_first: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL ptr_second: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ptr_end: got %b expected 0100", req_ready);
    end
    tick();
    idle(4);
  endtask

  task automatic test_bubbles();
    bit expV;
    for (int c = 0; c < 24; c++) begin
      expV = (c >= 2) && ((c - 2) % 2 == 0) && ((c - 2) / 2 < 10);
      checks++;
      if (rsp_valid !== expV) begin
        failures++;
        $display("FAIL bubble_valid[%0d]: got %0b expected %0b", c, rsp_valid, expV);
      end
      req_valid = '0;
      if (c % 2 == 0 && c < 20) begin
        req_valid[$urandom_range(0, 3)] = 1'b1;
        req_ops = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_random();
    logic [N-1:0] acc = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || acc[k]) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          req_ops[32*k +: 32] = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
    end
    idle(5);
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b0011;
    req_ops = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready = 1'b1;
    repeat (2) tick();
    req_valid = 4'b1010;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || add_enable !== 1'b1 ||
        rsp_id !== 2'd0 || {add_d, add_c, add_b, add_a} !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%0b busy=%0b ready=%b en=%0b id=%0d ops=%h expected 0,0,0000,1,0,0",
               rsp_valid, busy, req_ready, add_enable, rsp_id, {add_d, add_c, add_b, add_a});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL midreset_grant: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_stale: got rsp_valid=%0b expected 0", rsp_valid);
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_backpressure();
    test_pointer();
    test_bubbles();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/add4_rr_sched.md
Name: add4_rr_sched

Overview:
- Round-robin scheduler that shares one 2-stage pipelined 4-operand adder (8-bit operands, 10-bit sum, global enable) among N requesters.
- Accepts operand sets over per-requester valid/ready handshakes and drives the adder's operand and enable inputs.
- Tracks in-flight slots with a valid/ID shadow pipeline aligned to the adder stages.
- Returns each sum with its requester ID over a valid/ready response port.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_req_valid  input  N  per-requester operand-set valid
- i_req_ops  input  N*32  requester k operands at [32k+31:32k], ordered {d,c,b,a}, a in low byte
- o_req_ready  output  N  per-requester accept; one-hot or zero
- o_add_enable  output  1  adder pipeline enable
- o_add_a, o_add_b, o_add_c, o_add_d  output  8 each  adder operands
- i_add_sum  input  10  adder output register
- o_rsp_valid  output  1  response valid
- o_rsp_id  output  ID_W  requester ID of the response
- o_rsp_sum  output  10  response sum; combinational from i_add_sum
- i_rsp_ready  input  1  downstream accepts response
- o_busy  output  1  any slot in flight

Behaviour:
- Reset (async assert, sync use): v1=0, v2=0, id1=0, id2=0, rr pointer=0. Outputs: o_rsp_valid=0, o_rsp_id=0, o_req_ready=0, o_busy=0, o_add_enable=1, operands=0.
- adv = ~v2 | i_rsp_ready. o_add_enable = adv.
- Shadow pipeline updates only when adv=1:
  - v1 <= any grant; id1 <= granted index.
  - v2 <= v1; id2 <= id1.
- When adv=0, all state holds, including the adder's registers.
- Arbitration:
  - grant = first k with i_req_valid[k]=1, searching ptr, ptr+1, ... mod N.
  - o_req_ready[k] = adv & grant[k].
  - A transfer occurs when i_req_valid[k] & o_req_ready[k].
  - On a transfer, ptr <= (k+1) mod N. With no transfer, ptr holds.
- Operand mux: o_add_a..d come from the granted requester's slice. With no grant they are 0, and the bubble is marked by v1=0.
- Latency: operands transferred at edge t appear as a response in the cycle after edge t+1, provided adv=1 at t and t+1. Stalls extend latency by the number of stalled cycles.
- Response outputs: o_rsp_valid=v2, o_rsp_id=id2, o_rsp_sum=i_add_sum. The response is consumed when o_rsp_valid & i_rsp_ready.
- Backpressure: while o_rsp_valid=1 and i_rsp_ready=0:
  - adv=0; no grants.
  - o_rsp_valid/id/sum stay stable.
  - The request in stage 1 is held, not dropped.
- Throughput: with i_rsp_ready held at 1, one accept per cycle. The bubble rule keeps v2 equal to the real presence of a result.
- Fairness: a continuously asserting requester waits at most N-1 transfers between its own grants.
- Requester rules:
  - A requester must hold i_req_valid and its operands stable until accepted.
  - Deasserting before acceptance is allowed; the operands are not captured.
- o_busy = v1 | v2.
- Reset mid-operation: in-flight entries are discarded with no response. The adder is reset on the same i_rst_n.
- Arithmetic: sum width is 10 bits, max 4*255 = 1020; no overflow handling is required.

Test Plan:
- Single request: requester 2 sends a=1,b=2,c=3,d=4; rsp_ready=1 -> o_req_ready=4'b0100 that cycle; two edges later o_rsp_valid=1, id=2, sum=10; then valid=0.
- All four valid continuously, ops=255 each, rsp_ready=1 -> grants rotate 0,1,2,3,0..., one per cycle; responses id 0,1,2,3... each sum=1020; no bubbles.
- Backpressure: stream from requester 0 (sums 4,8,12), drop rsp_ready for 3 cycles after the first response -> enable=0, o_req_ready=0, id/sum held at 4; on release sums 8 and 12 are delivered in order, none lost or duplicated.
- Pointer rotation: ptr=3 after a grant to 2, requests from 1 and 3 -> 3 granted first, then 1; ptr ends at 2.
- Bubbles: a request every other cycle -> v1 alternates; no spurious o_rsp_valid on bubble slots.
- Reset mid-flight: assert i_rst_n low with v1=v2=1 -> all outputs immediately at reset values; after release no stale responses appear, and the first grant goes to the lowest valid requester (ptr=0).
